// File: rtl/led_breathe.sv
// led_breathe: triangle-ramp PWM LED driver; all outputs registered, LED0 lags the PWM compare by 1 clock, no backpressure.
// Define LED_BREATHE_GAMMA_EN to square-map level into the PWM duty; default build drives duty = level directly.
module led_breathe #(
  parameter int PWM_BITS         = 8,
  parameter int PRESCALE         = 47,
  parameter int PERIODS_PER_STEP = 16
) (
  input  logic                int_osc,
  input  logic                rstn,
  input  logic                en,
  output logic                LED0,
  output logic [PWM_BITS-1:0] level,
  output logic                dir
);

  localparam int PRE_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int STEP_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_TC  = PRE_W'(PRESCALE);
  localparam logic [STEP_W-1:0]   STEP_TC = STEP_W'(PERIODS_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t              state;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_map;
  logic [STEP_W-1:0]   step_cnt;
  logic                tick;
  logic                period_end;
  logic                step;

  assign tick       = (pre_cnt == PRE_TC);
  assign period_end = tick && (pwm_cnt == MAX);
  assign step       = period_end && (step_cnt == STEP_TC);

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_ext;
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_ext = {{PWM_BITS{1'b0}}, level};
  assign level_sq  = level_ext * level_ext;
  assign duty_map  = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_map = level;
`endif

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty_q   <= '0;
      level    <= '0;
      dir      <= 1'b0;
      LED0     <= 1'b0;
    end else if (!en || state == IDLE) begin
      // Disable wins over any coincident step; IDLE spends one clock with counters parked at 0.
      state    <= en ? UP : IDLE;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty_q   <= '0;
      level    <= '0;
      dir      <= 1'b0;
      LED0     <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      // duty_q samples the pre-step level, so a new level shows on LED0 one period later.
      if (period_end) begin
        duty_q   <= duty_map;
        step_cnt <= step ? '0 : step_cnt + 1'b1;
      end
      LED0 <= (pwm_cnt < duty_q);
      if (step) begin
        case (state)
          UP: begin
            if (level == MAX) begin
              level <= MAX - ONE;
              dir   <= 1'b1;
              state <= DOWN;
            end else begin
              level <= level + ONE;
            end
          end
          DOWN: begin
            if (level == '0) begin
              level <= ONE;
              dir   <= 1'b0;
              state <= UP;
            end else begin
              level <= level - ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
